round_robin_arbiter_n_hold: RTL and testbench



---
 rtl/round_robin_arbiter_pkg.sv | 7 +
 rtl/round_robin_arbiter_n_hold_rr_pick.sv | 26 ++
 rtl/round_robin_arbiter_n_hold.sv | 58 +++++
 tb/tb_round_robin_arbiter_n_hold.sv | 127 ++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: shared types and helpers for the round-robin arbiter
package round_robin_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;
  function automatic int wrap_inc(int v, int n);
    return (v + 1 == n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/round_robin_arbiter_n_hold_rr_pick.sv
// rr_pick: combinational circular priority picker, first set bit at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    onehot = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/round_robin_arbiter_n_hold.sv
// round_robin_arbiter_n_hold: round-robin arbiter with grant locking up to MAX_HOLD cycles
module round_robin_arbiter_n_hold
  import round_robin_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grants,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_t state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, pick_idx, id_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0] pick_onehot, grants_nxt;
  logic pick_found, keep, take;
  rr_pick #(.N(N)) u_pick (
    .req(requests),
    .ptr(ptr),
    .found(pick_found),
    .idx(pick_idx),
    .onehot(pick_onehot)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grants <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      hold_cnt <= hold_nxt;
      grants <= grants_nxt;
      grant_id <= id_nxt;
      grant_valid <= |grants_nxt;
    end
  end
  // Owner stays locked until release or timeout; otherwise re-arbitrate from ptr
  always_comb begin
    keep = (state == ST_GRANT) && requests[grant_id] && (hold_cnt < HW'(MAX_HOLD));
    take = !keep && pick_found;
    state_nxt = (keep || take) ? ST_GRANT : ST_IDLE;
  end
  always_comb begin
    grants_nxt = take ? pick_onehot : keep ? grants : '0;
    id_nxt = take ? pick_idx : keep ? grant_id : '0;
    hold_nxt = take ? HW'(1) : keep ? hold_cnt + HW'(1) : '0;
    ptr_nxt = take ? IW'(wrap_inc(int'(pick_idx), N)) : ptr;
  end
endmodule

// File: tb/tb_round_robin_arbiter_n_hold.sv
// tb_round_robin_arbiter_n_hold: scoreboard bench with a behavioural arbiter model
module tb_round_robin_arbiter_n_hold;
  import round_robin_arbiter_pkg::*;
  localparam int N = 4;
  localparam int MH = 4;
  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic v;
    int h;
  } exp_t;
  logic clk, rst;
  logic [N-1:0] requests, grants;
  logic grant_valid;
  logic [1:0] grant_id;
  exp_t sb[$];
  int vectors = 0, errors = 0;
  int m_owner = -1, m_hold = 0, m_ptr = 0;
  round_robin_arbiter_n_hold #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .requests(requests),
    .grants(grants),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < N; i++)
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction
  task automatic model(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner >= 0 && r[m_owner] && m_hold < MH) begin
      m_hold++;
    end else begin
      w = pick(r);
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_ptr = (w + 1) % N;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end
  endtask
  task automatic step(input logic [3:0] r, input logic rs = 1'b0);
    exp_t e;
    @(negedge clk);
    requests = r;
    rst = rs;
    model(r, rs);
    e.g = '0;
    if (m_owner >= 0) e.g[m_owner] = 1'b1;
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.v = (m_owner >= 0);
    e.h = m_hold;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grants", 32'(grants), 32'(e.g));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("grant_valid", 32'(grant_valid), 32'(e.v));
    chk("hold_cnt", 32'(dut.hold_cnt), 32'(e.h));
  endtask
  initial begin
    rst = 1;
    requests = '0;
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("rst_grants", 32'(grants), 32'h0);
    step(4'b1111);
    chk("first_grant", 32'(grants), 32'b0001);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001);
      chk("single", 32'(grants), 32'b0001);
    end
    step(4'b0000);
    chk("release_valid", 32'(grant_valid), 32'h0);
    chk("release_idle", 32'(dut.state == ST_IDLE), 32'h1);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(4'b1111);
      chk("rot_id", 32'(grant_id), 32'((i / 4) % 4));
    end
    step(4'b0000, 1'b1);
    step(4'b0001);
    step(4'b1010);
    chk("handoff", 32'(grants), 32'b0010);
    step(4'b1000);
    chk("handoff2", 32'(grants), 32'b1000);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0100);
      chk("regrant", 32'(grants), 32'b0100);
      chk("regrant_hold", 32'(dut.hold_cnt), 32'((i % 4) + 1));
    end
    step(4'b0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(4'b0011);
      chk("starve", 32'(grants), ((i / 4) % 2) ? 32'b0010 : 32'b0001);
    end
    step(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0100);
    step(4'b0100, 1'b1);
    chk("mid_rst", 32'(grants), 32'h0);
    step(4'b1100);
    chk("post_rst", 32'(grants), 32'b0100);
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
